// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Definitions shared by the video transmit path and the capture side:
//   - tx_state_t : state encoding of the transmit frame-alignment FSM
//   - DEF_*      : default pixel geometry and raster timing
//   - cnt_width  : bits needed to hold 0..n inclusive
// ----------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        SEEK     = 2'd0,   // discard FIFO entries until a start-of-frame is at the head
        WAIT_FRM = 2'd1,   // start-of-frame at head, waiting for raster position 0/0
        RUN      = 2'd2    // streaming FIFO entries into the active window
    } tx_state_t;

    localparam int DEF_DW      = 8;
    localparam int DEF_IW      = 640;
    localparam int DEF_IH      = 512;
    localparam int DEF_H_TOTAL = 800;
    localparam int DEF_V_TOTAL = 600;
    localparam int DEF_SYNC_B  = 5;
    localparam int DEF_SYNC_E  = 55;
    localparam int DEF_VLD_B   = 65;
    localparam int DEF_H_ACT_B = 80;
    localparam int DEF_FIFO_AW = 4;

    // Width able to represent 0..n, so window end positions equal to the
    // raster total still fit in the counter type.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/video_tx_if.sv
// ----------------------------------------------------------------------------
// video_tx_if
// Local pixel stream into the transmitter (valid/ready handshake).
//   pix_dat : pixel data
//   pix_sof : marks the first pixel of a frame
//   pix_vld : pix_dat/pix_sof valid
//   pix_rdy : sink can accept; a transfer happens when pix_vld & pix_rdy
// Modports: master (pixel source), slave (transmitter).
// ----------------------------------------------------------------------------
interface video_tx_if
    import video_pkg::*;
#(
    parameter int DW = DEF_DW
);

    logic [DW-1:0] pix_dat;
    logic          pix_sof;
    logic          pix_vld;
    logic          pix_rdy;

    modport master (output pix_dat, output pix_sof, output pix_vld, input  pix_rdy);
    modport slave  (input  pix_dat, input  pix_sof, input  pix_vld, output pix_rdy);

endinterface

// File: rtl/pix_fifo.sv
// ----------------------------------------------------------------------------
// pix_fifo
// Synchronous show-ahead FIFO, depth 2**AW. The head entry is visible on
// rd_dat whenever empty is low; rd_en consumes it.
//   clk, reset_l : clock, asynchronous active-low reset (clears pointers)
//   wr_en/wr_dat : write request; ignored while full
//   rd_en/rd_dat : read request; ignored while empty
//   full, empty  : status
// ----------------------------------------------------------------------------
module pix_fifo #(
    parameter int W  = 9,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         wr_en,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_en,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit separates full (MSBs differ) from empty (equal).
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A write at full is refused even if a read happens in the same clock.
    assign do_wr  = wr_en && !full;
    assign do_rd  = rd_en && !empty;
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; clearing the pointers already
    // makes every stale entry unreachable, and a reset would block RAM mapping.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/video_tx.sv
// ----------------------------------------------------------------------------
// video_tx
// Raster timing generator plus frame-aligned pixel transmitter. Pixels are
// buffered in pix_fifo, aligned to the raster on their start-of-frame marker,
// and emitted one per active clock.
//   clk        : single clock, rising edge
//   reset_l    : asynchronous active-low reset
//   en         : timing enable; low freezes the raster counters and outputs
//   pix        : pixel stream in (video_tx_if.slave)
//   DVD        : output video data, zero outside the active window
//   DHSYN      : high during active pixels
//   DVSYN      : frame sync, high on lines SYNC_B..SYNC_E-1
//   underrun   : sticky, set on FIFO starvation or a misplaced start-of-frame
//   frame_done : one-clock pulse after the last active pixel of a frame
// ----------------------------------------------------------------------------
module video_tx
    import video_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int IW      = DEF_IW,
    parameter int IH      = DEF_IH,
    parameter int H_TOTAL = DEF_H_TOTAL,
    parameter int V_TOTAL = DEF_V_TOTAL,
    parameter int SYNC_B  = DEF_SYNC_B,
    parameter int SYNC_E  = DEF_SYNC_E,
    parameter int VLD_B   = DEF_VLD_B,
    parameter int H_ACT_B = DEF_H_ACT_B,
    parameter int FIFO_AW = DEF_FIFO_AW
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          en,
    video_tx_if.slave     pix,
    output logic [DW-1:0] DVD,
    output logic          DHSYN,
    output logic          DVSYN,
    output logic          underrun,
    output logic          frame_done
);

    localparam int HW = cnt_width(H_TOTAL);
    localparam int VW = cnt_width(V_TOTAL);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_LO  = HW'(H_ACT_B);
    localparam logic [HW-1:0] H_ACT_LEN = HW'(IW);
    localparam logic [HW-1:0] H_ACT_END = HW'(H_ACT_B + IW - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(SYNC_B);
    localparam logic [VW-1:0] V_SYNC_LN = VW'(SYNC_E - SYNC_B);
    localparam logic [VW-1:0] V_ACT_LO  = VW'(VLD_B);
    localparam logic [VW-1:0] V_ACT_LEN = VW'(IH);
    localparam logic [VW-1:0] V_ACT_END = VW'(VLD_B + IH - 1);

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Window tests as offset-below-length: one unsigned compare each, which
    // also stays well-formed when a window starts at position 0.
    logic h_act, v_act, v_sync, active, first_pix, last_pix, frame_start;

    assign h_act       = HW'(h_cnt - H_ACT_LO) < H_ACT_LEN;
    assign v_act       = VW'(v_cnt - V_ACT_LO) < V_ACT_LEN;
    assign v_sync      = VW'(v_cnt - V_SYNC_LO) < V_SYNC_LN;
    assign active      = en && h_act && v_act;
    assign first_pix   = (h_cnt == H_ACT_LO)  && (v_cnt == V_ACT_LO);
    assign last_pix    = (h_cnt == H_ACT_END) && (v_cnt == V_ACT_END);
    assign frame_start = en && (h_cnt == '0) && (v_cnt == '0);

    // ------------------------------------------------------------------
    // Pixel FIFO: entries are {sof, data}
    // ------------------------------------------------------------------
    logic [DW:0]   fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          head_sof;
    logic [DW-1:0] head_dat;

    pix_fifo #(
        .W  (DW + 1),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .wr_en   (pix.pix_vld),
        .wr_dat  ({pix.pix_sof, pix.pix_dat}),
        .rd_en   (pop),
        .rd_dat  (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pix.pix_rdy = !fifo_full;
    assign head_sof    = fifo_head[DW];
    assign head_dat    = fifo_head[DW-1:0];

    // ------------------------------------------------------------------
    // Frame-alignment FSM
    // ------------------------------------------------------------------
    tx_state_t     state_q, state_d;
    logic          run_now;    // this clock streams pixels
    logic          und_set;
    logic          last_pop;   // last pixel of the frame leaves the FIFO now
    logic          done_pend;  // clock after last_pop: frame_done and re-arm decision
    logic [DW-1:0] dvd_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        run_now  = 1'b0;
        und_set  = 1'b0;
        last_pop = 1'b0;
        dvd_d    = '0;

        unique case (state_q)
            SEEK: begin
                if (!fifo_empty) begin
                    if (head_sof) state_d = WAIT_FRM;
                    else          pop     = 1'b1;
                end
            end
            WAIT_FRM: begin
                // Entering RUN also streams this clock, in case the active
                // window begins at raster position 0/0.
                if (frame_start) begin
                    state_d = RUN;
                    run_now = 1'b1;
                end
            end
            RUN: begin
                // The head is inspected one clock after the last pop, once
                // the FIFO read pointer has moved past the final pixel.
                if (done_pend) begin
                    if (!fifo_empty && head_sof) begin
                        if (frame_start) run_now = 1'b1;
                        else             state_d = WAIT_FRM;
                    end else begin
                        state_d = SEEK;
                    end
                end else begin
                    run_now = 1'b1;
                end
            end
            default: state_d = SEEK;
        endcase

        if (run_now && active) begin
            if (fifo_empty) begin
                und_set = 1'b1;
                state_d = SEEK;
            end else begin
                pop   = 1'b1;
                dvd_d = head_dat;
                // A start-of-frame anywhere but the first pixel means the
                // source lost alignment: show it, flag it, resynchronise.
                if (head_sof && !first_pix) begin
                    und_set = 1'b1;
                    state_d = SEEK;
                end
                if (last_pix) last_pop = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= SEEK;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            DVD        <= '0;
            DHSYN      <= 1'b0;
            DVSYN      <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_pend  <= last_pop;
            frame_done <= done_pend;
            if (und_set) underrun <= 1'b1;
            // Video outputs follow the counters and freeze with them.
            if (en) begin
                DVD   <= dvd_d;
                DHSYN <= h_act && v_act;
                DVSYN <= v_sync;
            end
        end
    end

endmodule

// File: doc/video_tx.md
VIDEO_TX -- requirements
Module: video_tx

Interface
REQ-001 SHALL have parameters: DW, default 8, pixel data width; IW, default 640, active pixels per line; IH, default 512, active lines per frame.
REQ-002 SHALL have timing parameters: H_TOTAL, default 800, clocks per line; V_TOTAL, default 600, lines per frame; SYNC_B, default 5, first DVSYN-high line; SYNC_E, default 55, first DVSYN-low line after sync; VLD_B, default 65, first active line; H_ACT_B, default 80, first active clock in a line; FIFO_AW, default 4, FIFO address width.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port reset_l  in  1  asynchronous, active-low reset.
REQ-005 Port en  in  1  timing-generator enable.
REQ-006 Port pix_dat  in  DW  local pixel in.
REQ-007 Port pix_sof  in  1  marks first pixel of a frame.
REQ-008 Port pix_vld  in  1  pix_dat/pix_sof valid.
REQ-009 Port pix_rdy  out  1  FIFO not full; transfer when pix_vld&pix_rdy.
REQ-010 Port DVD  out  DW  output video data.
REQ-011 Port DHSYN  out  1  high during active pixels.
REQ-012 Port DVSYN  out  1  frame sync.
REQ-013 Port underrun  out  1  sticky underflow flag.
REQ-014 Port frame_done  out  1  one-clock pulse after last active pixel of a frame.

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0, incrementing v_cnt (0..V_TOTAL-1, wrap to 0), only while en=1; en=0 freezes both counters and holds outputs.
REQ-016 DVSYN SHALL be high when SYNC_B <= v_cnt < SYNC_E.
REQ-017 Active window SHALL be VLD_B <= v_cnt < VLD_B+IH and H_ACT_B <= h_cnt < H_ACT_B+IW; DHSYN high exactly then.
REQ-018 All outputs SHALL be registered: DVD/DHSYN/DVSYN lag the counter state by exactly 1 clock; DVD = 0 whenever DHSYN=0.
REQ-019 FIFO SHALL store {pix_sof, pix_dat}, depth 2^FIFO_AW; pix_rdy = not full; simultaneous write and read at full or empty SHALL both succeed when legal (write at full blocked, read at empty blocked).
REQ-020 State machine SHALL have states SEEK, WAIT_FRM, RUN.
REQ-021 SEEK: pop and discard FIFO entries until head has pix_sof=1, then go to WAIT_FRM without popping.
REQ-022 WAIT_FRM: at v_cnt=0, h_cnt=0 with en=1, go to RUN; DHSYN still asserts in window during WAIT_FRM but DVD = 0.
REQ-023 RUN: each active clock pops one entry to DVD; exactly IW*IH pops per frame.
REQ-024 RUN, active clock, FIFO empty: DVD = 0, underrun set, go to SEEK.
REQ-025 RUN, popped entry with pix_sof=1 other than the first pixel of the frame: output it, set underrun, go to SEEK.
REQ-026 After last active pixel: pulse frame_done next clock; go to SEEK if head not sof, else WAIT_FRM.
REQ-027 underrun SHALL clear only on reset.

Reset
REQ-028 reset_l=0 SHALL asynchronously clear h_cnt, v_cnt, FIFO pointers, DVD, DHSYN, DVSYN, underrun, frame_done; state goes to SEEK; pix_rdy = 1 after release.
REQ-029 Reset mid-frame SHALL discard FIFO contents; first output frame after release starts at next v_cnt=0.

Structure
REQ-030 Shared package video_pkg SHALL hold the state enum and default timing constants shared with the capture side.
REQ-031 FIFO SHALL be sub-module pix_fifo (sync, show-ahead); counters and FSM stay in video_tx.

Verification (IW=4, IH=2, H_TOTAL=8, V_TOTAL=6, SYNC_B=0, SYNC_E=1, VLD_B=2, H_ACT_B=2, FIFO_AW=3)
REQ-032 Push 8 pixels 0x10..0x17 (sof on first), en=1 -> DVSYN high on line 0; DHSYN high clocks 2-5 of lines 2-3; DVD 10,11,12,13 then 14..17; frame_done one pulse; underrun=0.
REQ-033 Push only 5 pixels -> 6th active clock DVD=0, underrun=1, state SEEK, next frame DVD=0 until new sof.
REQ-034 Push 3 junk pixels (sof=0) then a valid frame -> junk discarded, frame output exactly as REQ-032.
REQ-035 Hold pix_vld=1 with no reads during WAIT_FRM -> pix_rdy drops after 8 writes; no data lost or duplicated.
REQ-036 Assert reset_l=0 on line 3 mid-frame -> all outputs 0 immediately, FIFO empty, underrun=0; clean frame follows after release.
